// File: rtl/hilo_mult_unit.sv
// Iterative radix-2 shift-add multiply / multiply-accumulate unit owning the HI and LO registers.
// Products are formed on operand magnitudes; the sign is applied when HI:LO is updated.
module hilo_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Madd,
  input  logic             Msub,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             HiOrLo,
  output logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StMul    = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  localparam logic [1:0] OpMult = 2'd0;
  localparam logic [1:0] OpMadd = 2'd1;
  localparam logic [1:0] OpMsub = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] acc;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // Negating the most negative value yields the exact unsigned magnitude 2^(WIDTH-1).
    abs_a = (Signed && A[WIDTH-1]) ? -A : A;
    abs_b = (Signed && B[WIDTH-1]) ? -B : B;
    sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    p     = neg_q ? -prod_q : prod_q;
    acc   = {hi_q, lo_q};

    case (state_q)
      StIdle: begin
        if (WriteHi) hi_d = WriteData;
        if (WriteLo) lo_d = WriteData;
        if (Start && !(Madd && Msub)) begin
          mcand_d  = abs_a;
          mplier_d = abs_b;
          neg_d    = (A[WIDTH-1] ^ B[WIDTH-1]) & Signed;
          op_d     = Madd ? OpMadd : (Msub ? OpMsub : OpMult);
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = StMul;
        end
      end
      StMul: begin
        prod_d   = {sum, prod_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StCommit;
      end
      StCommit: begin
        case (op_q)
          OpMadd:  {hi_d, lo_d} = acc + p;
          OpMsub:  {hi_d, lo_d} = acc - p;
          default: {hi_d, lo_d} = p;
        endcase
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= StIdle;
      op_q     <= OpMult;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign ReadData = HiOrLo ? hi_q : lo_q;
  assign Busy     = (state_q != StIdle);
  assign Done     = done_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed self-checking bench for hilo_mult_unit: latency, signed/unsigned products,
// accumulate/subtract, busy-time lockout, direct writes and asynchronous reset.
module tb_hilo_mult_unit;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic         Madd = 1'b0;
  logic         Msub = 1'b0;
  logic         Signed = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         WriteHi = 1'b0;
  logic         WriteLo = 1'b0;
  logic [W-1:0] WriteData = '0;
  logic         HiOrLo = 1'b0;
  logic [W-1:0] ReadData;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;

  int errors = 0;
  int checks = 0;
  int busy_cycles;
  int done_pulses;

  hilo_mult_unit #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Madd      (Madd),
    .Msub      (Msub),
    .Signed    (Signed),
    .A         (A),
    .B         (B),
    .WriteHi   (WriteHi),
    .WriteLo   (WriteLo),
    .WriteData (WriteData),
    .HiOrLo    (HiOrLo),
    .ReadData  (ReadData),
    .Hi        (Hi),
    .Lo        (Lo),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation at a negedge and waits (bounded) for Busy to drop.
  // With inject set, a Start with other operands and a WriteLo are pulsed mid-operation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic madd, input logic msub, input logic inject);
    A = a; B = b; Signed = sgn; Madd = madd; Msub = msub; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0; Madd = 1'b0; Msub = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Done) done_pulses++;
      if (!Busy) break;
      busy_cycles++;
      if (inject && busy_cycles == 5) begin
        A = 32'd3; B = 32'd3; Start = 1'b1; WriteLo = 1'b1; WriteData = 32'h1234;
      end else begin
        Start = 1'b0; WriteLo = 1'b0;
      end
    end
    Start = 1'b0; WriteLo = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_hi", 64'(Hi), 64'h0);
    check("reset_lo", 64'(Lo), 64'h0);
    check("reset_busy", 64'(Busy), 64'h0);
    check("reset_done", 64'(Done), 64'h0);
    @(negedge Clk);
    Rst = 1'b1;

    // Unsigned max x max with busy-time Start/WriteLo ignored
    @(negedge Clk);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    check("umax_busy_cycles", 64'(busy_cycles), 64'd33);
    check("umax_done", 64'(Done), 64'h1);
    check("umax_hi", 64'(Hi), 64'hFFFFFFFE);
    check("umax_lo", 64'(Lo), 64'h00000001);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (Done) done_pulses++;
    end
    check("umax_done_pulses", 64'(done_pulses), 64'd1);
    check("umax_idle_after", 64'(Busy), 64'h0);
    check("umax_hi_hold", 64'(Hi), 64'hFFFFFFFE);
    check("umax_lo_hold", 64'(Lo), 64'h00000001);

    // Signed mult, then madd and msub back-to-back
    run_op(-32'sd3, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("smul_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(32'd5, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    check("smadd_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    check("smsub_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFE);
    check("smsub_busy_cycles", 64'(busy_cycles), 64'd33);

    // Most negative squared
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("minneg_hilo", {Hi, Lo}, 64'h40000000_00000000);

    // Direct writes then msub onto the written value
    @(negedge Clk);
    WriteLo = 1'b1; WriteData = 32'h5;
    @(negedge Clk);
    WriteLo = 1'b0; WriteHi = 1'b1; WriteData = 32'h0;
    @(negedge Clk);
    WriteHi = 1'b0;
    check("write_hilo", {Hi, Lo}, 64'h00000000_00000005);
    run_op(32'd2, 32'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    check("wmsub_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);
    HiOrLo = 1'b0; #1;
    check("read_lo", 64'(ReadData), 64'hFFFFFFFF);
    HiOrLo = 1'b1; #1;
    check("read_hi", 64'(ReadData), 64'hFFFFFFFF);

    // Illegal Madd&Msub request
    @(negedge Clk);
    WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'h00C0FFEE;
    @(negedge Clk);
    WriteHi = 1'b0; WriteLo = 1'b0;
    A = 32'd9; B = 32'd9; Signed = 1'b0; Madd = 1'b1; Msub = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Madd = 1'b0; Msub = 1'b0;
    check("illegal_busy", 64'(Busy), 64'h0);
    @(negedge Clk);
    check("illegal_done", 64'(Done), 64'h0);
    check("illegal_hilo", {Hi, Lo}, 64'h00C0FFEE_00C0FFEE);

    // Asynchronous reset mid-operation
    A = 32'd100; B = 32'd200; Signed = 1'b0; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int i = 0; i < 11; i++) @(negedge Clk);
    check("midop_busy", 64'(Busy), 64'h1);
    #2 Rst = 1'b0;
    #1;
    check("arst_hi", 64'(Hi), 64'h0);
    check("arst_lo", 64'(Lo), 64'h0);
    check("arst_busy", 64'(Busy), 64'h0);
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 40; i++) @(negedge Clk);
    check("post_rst_hilo", {Hi, Lo}, 64'h0);
    check("post_rst_busy", 64'(Busy), 64'h0);
    check("post_rst_done", 64'(Done), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Multi-cycle multiply / multiply-accumulate unit that owns the architectural HI and LO registers.
- Sits directly downstream of instruction decode. Consumes the decode strobes for mult, multu, madd and msub, plus the register-file operands A and B.
- Serves mfhi/mflo-style reads (HiOrLo select) and mthi/mtlo-style writes back to the datapath.
- Uses an iterative radix-2 shift-add engine and exposes a Busy stall to the pipeline.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH bits.

Ports:
Clk  input  1  clock; all state updates on rising edge.
Rst  input  1  asynchronous, active-low reset.
Start  input  1  one-cycle request to begin an operation; decode drives it from HiLoWrite|Madd|Msub.
Madd  input  1  accumulate the product into HI:LO.
Msub  input  1  subtract the product from HI:LO.
Signed  input  1  1 = two's-complement operands; 0 = unsigned.
A  input  WIDTH  multiplicand (rs).
B  input  WIDTH  multiplier (rt).
WriteHi  input  1  load HI from WriteData.
WriteLo  input  1  load LO from WriteData.
WriteData  input  WIDTH  data for WriteHi / WriteLo.
HiOrLo  input  1  read select: 1 = HI, 0 = LO.
ReadData  output  WIDTH  combinational read of HI or LO per HiOrLo.
Hi  output  WIDTH  current HI register.
Lo  output  WIDTH  current LO register.
Busy  output  1  operation in flight; the pipeline stalls on it.
Done  output  1  one-cycle pulse on the cycle HI/LO take a new product result.

Behaviour:
- Reset (Rst=0, asynchronous):
  - Hi=0, Lo=0, Busy=0, Done=0.
  - State=IDLE; internal accumulator and counter cleared.
  - Any in-flight operation is abandoned with no HI/LO update.
- States: IDLE, MUL, COMMIT.
- IDLE:
  - When Start=1 and Madd&Msub=0: latch |A| and |B| (magnitude if Signed, raw otherwise), latch the result sign (A[WIDTH-1]^B[WIDTH-1])&Signed, latch the op (mult/madd/msub), clear the 2*WIDTH product and the counter. Next state is MUL.
  - When Start=1 and Madd=Msub=1: illegal request; no state change, no HI/LO change.
  - Magnitude of the most negative value (0x80000000) is computed as an unsigned 2^31, so it is exact.
- MUL:
  - One iteration per cycle: if multiplier LSB=1, add the multiplicand into the upper half of the product; shift right one bit.
  - Counter counts to WIDTH, then next state is COMMIT.
  - Exactly WIDTH cycles are spent in MUL.
- COMMIT (single cycle):
  - P = sign ? -product : product, taken over 2*WIDTH bits.
  - mult: {Hi,Lo} <= P.
  - madd: {Hi,Lo} <= {Hi,Lo}+P.
  - msub: {Hi,Lo} <= {Hi,Lo}-P.
  - All arithmetic is modulo 2^(2*WIDTH); no overflow flag.
  - Done=1 for the cycle following the COMMIT edge; state returns to IDLE.
- Latency:
  - Start sampled at edge E0; Busy=1 from after E0 through E(WIDTH+1).
  - HI/LO are updated at edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - Busy=0 and Done=1 in the cycle following E(WIDTH+1).
  - A new Start is accepted in that same cycle (back-to-back allowed).
- Busy semantics:
  - Start while Busy is ignored and not queued.
  - WriteHi/WriteLo while Busy are ignored.
  - ReadData, Hi and Lo show the old values until commit.
- WriteHi / WriteLo:
  - Effective only in IDLE, in the same edge that would otherwise be idle.
  - Both may assert together, loading both registers.
  - If Start and WriteHi/WriteLo occur in the same IDLE cycle, the write is applied first; a madd/msub started that cycle accumulates onto the written value.
- A and B are only sampled at Start; changes during MUL have no effect.
- Done is registered; it never asserts without a preceding accepted Start.

Test Plan:
- Reset → Rst low mid-operation at MUL counter=10 → Hi=0, Lo=0, Busy=0 immediately; after release an idle Start-free window keeps Hi/Lo=0.
- Unsigned mult 0xFFFFFFFF×0xFFFFFFFF (Signed=0) → Busy high 33 cycles, then Hi=0xFFFFFFFE, Lo=0x00000001, Done single-cycle pulse.
- Signed mult −3×7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then signed madd 5×4 → Hi:Lo=0xFFFFFFFF:0xFFFFFFFF (−1). Then signed msub (−1)×(−1) → Hi:Lo=0xFFFFFFFF:0xFFFFFFFE.
- Signed mult 0x80000000×0x80000000 → Hi=0x40000000, Lo=0x00000000.
- Start pulse and WriteLo=1 (WriteData=0x1234) while Busy → ignored; final Hi/Lo equal the first op's result; exactly one Done pulse.
- In IDLE, WriteLo with WriteData=0x5, WriteHi with WriteData=0x0, then msub 2×3 (Signed=1) → Hi=0xFFFFFFFF, Lo=0xFFFFFFFF; HiOrLo=0 gives ReadData=0xFFFFFFFF, HiOrLo=1 gives 0xFFFFFFFF. Madd=Msub=1 with Start → no Busy, no change.
